cv32e40s_data_obi_responder: RTL and testbench

//  OBI data-side responder (subordinate end) with Xsecure integrity. Accepts
//  OBI A-channel transfers from a core data master, checks reqpar/achk, and

---
 rtl/cv32e40s_data_obi_responder.sv | 121 ++++++++++++
 tb/tb_cv32e40s_data_obi_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40s_data_obi_responder.sv
// OBI data-side responder with Xsecure integrity: checks reqpar/achk on the A channel,
// forwards clean transfers to an in-order backend, returns responses with gntpar/rvalidpar/rchk.
module cv32e40s_data_obi_responder #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        obi_req_i,
  input  logic        obi_reqpar_i,
  input  logic [31:0] obi_addr_i,
  input  logic        obi_we_i,
  input  logic [3:0]  obi_be_i,
  input  logic [31:0] obi_wdata_i,
  input  logic [2:0]  obi_prot_i,
  input  logic [1:0]  obi_memtype_i,
  input  logic        obi_dbg_i,
  input  logic [11:0] obi_achk_i,
  output logic        obi_gnt_o,
  output logic        obi_gntpar_o,
  output logic        obi_rvalid_o,
  output logic        obi_rvalidpar_o,
  output logic [31:0] obi_rdata_o,
  output logic        obi_err_o,
  output logic [4:0]  obi_rchk_o,
  output logic        mem_req_o,
  input  logic        mem_ready_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        integrity_err_o
);

  // Handshakes: an OBI transfer moves on obi_req_i & obi_gnt_o; a backend transfer
  // moves on mem_req_o & mem_ready_i; obi_rvalid_o and mem_rvalid_i have no back-pressure.
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] bcnt_q;
  logic          local_q;
  logic [11:0]   achk_exp;
  logic          achk_ok;
  logic          space;
  logic          mem_accept;
  logic          bad_gnt;
  logic          rsp_mem;
  logic          spurious;

  assign achk_exp = {^obi_wdata_i[31:24], ^obi_wdata_i[23:16], ^obi_wdata_i[15:8], ^obi_wdata_i[7:0],
                     1'b0, ~^obi_dbg_i, ~^{obi_be_i, obi_we_i}, ~^{obi_prot_i, obi_memtype_i},
                     ^obi_addr_i[31:24], ^obi_addr_i[23:16], ^obi_addr_i[15:8], ^obi_addr_i[7:0]};
  assign achk_ok  = (obi_achk_i == achk_exp);

  // A pending local error response blocks new grants so it can never collide with backend data.
  assign space      = (cnt_q < CW'(MAX_OUTSTANDING)) && !local_q;
  assign mem_req_o  = obi_req_i & achk_ok & space;
  assign mem_accept = mem_req_o & mem_ready_i;
  assign bad_gnt    = obi_req_i & !achk_ok & space & (bcnt_q == '0);
  assign obi_gnt_o  = mem_accept | bad_gnt;

  assign mem_addr_o  = obi_addr_i;
  assign mem_we_o    = obi_we_i;
  assign mem_be_o    = obi_be_i;
  assign mem_wdata_o = obi_wdata_i;

  assign rsp_mem  = mem_rvalid_i & (bcnt_q != '0);
  assign spurious = mem_rvalid_i & (bcnt_q == '0);

  assign obi_gntpar_o    = ~obi_gnt_o;
  assign obi_rvalidpar_o = ~obi_rvalid_o;
  assign obi_rchk_o      = {^{obi_err_o, 1'b0}, ^obi_rdata_o[31:24], ^obi_rdata_o[23:16],
                            ^obi_rdata_o[15:8], ^obi_rdata_o[7:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      bcnt_q <= '0;
    end else begin
      case ({obi_gnt_o, obi_rvalid_o})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      case ({mem_accept, rsp_mem})
        2'b10:   bcnt_q <= bcnt_q + CW'(1);
        2'b01:   bcnt_q <= bcnt_q - CW'(1);
        default: bcnt_q <= bcnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      local_q         <= 1'b0;
      obi_rvalid_o    <= 1'b0;
      obi_rdata_o     <= '0;
      obi_err_o       <= 1'b0;
      integrity_err_o <= 1'b0;
    end else begin
      integrity_err_o <= (obi_req_i == obi_reqpar_i) | (obi_req_i & !achk_ok) | spurious;
      if (rsp_mem) begin
        obi_rvalid_o <= 1'b1;
        obi_rdata_o  <= mem_rdata_i;
        obi_err_o    <= mem_err_i;
        if (bad_gnt) local_q <= 1'b1;
      end else if (local_q) begin
        obi_rvalid_o <= 1'b1;
        obi_rdata_o  <= '0;
        obi_err_o    <= 1'b1;
        local_q      <= 1'b0;
      end else begin
        obi_rvalid_o <= 1'b0;
        if (bad_gnt) local_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40s_data_obi_responder.sv
// Directed bench for cv32e40s_data_obi_responder: inputs change on the falling edge,
// combinational outputs checked 1ns later, registered outputs checked one falling edge on.
module tb_cv32e40s_data_obi_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        obi_req_i = 1'b0;
  logic        obi_reqpar_i = 1'b1;
  logic [31:0] obi_addr_i = '0;
  logic        obi_we_i = 1'b0;
  logic [3:0]  obi_be_i = 4'hF;
  logic [31:0] obi_wdata_i = '0;
  logic [2:0]  obi_prot_i = '0;
  logic [1:0]  obi_memtype_i = '0;
  logic        obi_dbg_i = 1'b0;
  logic [11:0] obi_achk_i = '0;
  logic        obi_gnt_o, obi_gntpar_o, obi_rvalid_o, obi_rvalidpar_o, obi_err_o;
  logic [31:0] obi_rdata_o;
  logic [4:0]  obi_rchk_o;
  logic        mem_req_o, mem_we_o;
  logic        mem_ready_i = 1'b1;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_err_i = 1'b0;
  logic        integrity_err_o;

  int tests = 0;
  int fails = 0;
  int gnt_count;

  cv32e40s_data_obi_responder #(.MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst(rst),
    .obi_req_i(obi_req_i), .obi_reqpar_i(obi_reqpar_i), .obi_addr_i(obi_addr_i),
    .obi_we_i(obi_we_i), .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i),
    .obi_prot_i(obi_prot_i), .obi_memtype_i(obi_memtype_i), .obi_dbg_i(obi_dbg_i),
    .obi_achk_i(obi_achk_i), .obi_gnt_o(obi_gnt_o), .obi_gntpar_o(obi_gntpar_o),
    .obi_rvalid_o(obi_rvalid_o), .obi_rvalidpar_o(obi_rvalidpar_o),
    .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o), .obi_rchk_o(obi_rchk_o),
    .mem_req_o(mem_req_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .integrity_err_o(integrity_err_o)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [11:0] achk_f(input logic [31:0] a, input logic we, input logic [3:0] be,
                                         input logic [31:0] wd, input logic [2:0] prot,
                                         input logic [1:0] mt, input logic dbg);
    logic [11:0] r;
    r[11] = ^wd[31:24]; r[10] = ^wd[23:16]; r[9] = ^wd[15:8]; r[8] = ^wd[7:0];
    r[7]  = 1'b0;
    r[6]  = ~dbg;
    r[5]  = ~(^be ^ we);
    r[4]  = ~(^prot ^ ^mt);
    r[3]  = ^a[31:24]; r[2] = ^a[23:16]; r[1] = ^a[15:8]; r[0] = ^a[7:0];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: drive a request; bad=1 flips achk[11]
  task automatic drive_req(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic bad);
    obi_req_i    = 1'b1;
    obi_reqpar_i = 1'b0;
    obi_addr_i   = a;
    obi_we_i     = we;
    obi_wdata_i  = wd;
    obi_achk_i   = achk_f(a, we, obi_be_i, wd, obi_prot_i, obi_memtype_i, obi_dbg_i) ^ (bad ? 12'h800 : 12'h000);
  endtask

  task automatic idle_req();
    obi_req_i    = 1'b0;
    obi_reqpar_i = 1'b1;
  endtask

  task automatic mem_rsp(input logic v, input logic [31:0] d, input logic e);
    mem_rvalid_i = v;
    mem_rdata_i  = d;
    mem_err_i    = e;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_gnt", obi_gnt_o, 0);
    chk("rst_gntpar", obi_gntpar_o, 1);
    chk("rst_rvalid", obi_rvalid_o, 0);
    chk("rst_rvalidpar", obi_rvalidpar_o, 1);
    chk("rst_rdata", obi_rdata_o, 0);
    chk("rst_err", obi_err_o, 0);
    chk("rst_integ", integrity_err_o, 0);
    chk("rst_memreq", mem_req_o, 0);
    chk("rst_rchk", obi_rchk_o, 0);
    cyc(); cyc();
    rst = 1'b0;

    // basic read, achk hand-computed for addr 0x100
    cyc();
    obi_req_i = 1'b1; obi_reqpar_i = 1'b0; obi_addr_i = 32'h100; obi_we_i = 1'b0;
    obi_wdata_i = '0; obi_achk_i = 12'h072;
    #1;
    chk("rd_gnt", obi_gnt_o, 1);
    chk("rd_gntpar", obi_gntpar_o, 0);
    chk("rd_memreq", mem_req_o, 1);
    chk("rd_memaddr", mem_addr_o, 32'h100);
    cyc(); idle_req(); mem_rsp(1'b1, 32'hDEADBEEF, 1'b0);
    #1;
    chk("rd_rvalid_early", obi_rvalid_o, 0);
    chk("rd_integ", integrity_err_o, 0);
    cyc(); mem_rsp(1'b0, 32'h0, 1'b0);
    #1;
    chk("rd_rvalid", obi_rvalid_o, 1);
    chk("rd_rvalidpar", obi_rvalidpar_o, 0);
    chk("rd_rdata", obi_rdata_o, 32'hDEADBEEF);
    chk("rd_err", obi_err_o, 0);
    chk("rd_rchk", obi_rchk_o, 5'b0_0101);
    cyc();
    #1;
    chk("rd_rvalid_drop", obi_rvalid_o, 0);
    chk("rd_rdata_hold", obi_rdata_o, 32'hDEADBEEF);

    // outstanding limit: req held 4 cycles, backend silent
    gnt_count = 0;
    drive_req(32'h200, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      if (obi_gnt_o) gnt_count++;
      cyc();
    end
    chk("lim_gnts", gnt_count, 2);
    mem_rsp(1'b1, 32'h11111111, 1'b0);
    #1;
    chk("lim_gnt_full", obi_gnt_o, 0);
    chk("lim_memreq_full", mem_req_o, 0);
    cyc(); mem_rsp(1'b0, 32'h0, 1'b0);
    #1;
    chk("lim_rvalid1", obi_rvalid_o, 1);
    chk("lim_rdata1", obi_rdata_o, 32'h11111111);
    chk("lim_gnt_wait", obi_gnt_o, 0);
    cyc();
    #1;
    chk("lim_gnt3", obi_gnt_o, 1);
    cyc(); idle_req(); mem_rsp(1'b1, 32'h22222222, 1'b0);
    cyc(); mem_rsp(1'b1, 32'h33333333, 1'b1);
    #1;
    chk("lim_rdata2", obi_rdata_o, 32'h22222222);
    cyc(); mem_rsp(1'b0, 32'h0, 1'b0);
    #1;
    chk("lim_rvalid3", obi_rvalid_o, 1);
    chk("lim_rdata3", obi_rdata_o, 32'h33333333);
    chk("lim_err3", obi_err_o, 1);
    chk("lim_rchk3", obi_rchk_o, 5'b1_0000);
    cyc();

    // bad achk write with empty backend
    drive_req(32'h300, 1'b1, 32'hA5A50F0F, 1'b1);
    #1;
    chk("bad_gnt", obi_gnt_o, 1);
    chk("bad_memreq", mem_req_o, 0);
    cyc(); drive_req(32'h400, 1'b0, 32'h0, 1'b0);
    #1;
    chk("bad_integ", integrity_err_o, 1);
    chk("bad_gnt_blocked", obi_gnt_o, 0);
    chk("bad_rvalid_early", obi_rvalid_o, 0);
    cyc();
    #1;
    chk("bad_rvalid", obi_rvalid_o, 1);
    chk("bad_err", obi_err_o, 1);
    chk("bad_rdata", obi_rdata_o, 0);
    chk("bad_rchk", obi_rchk_o, 5'b1_0000);
    chk("bad_integ_clear", integrity_err_o, 0);
    chk("bad_next_gnt", obi_gnt_o, 1);
    cyc(); idle_req(); mem_rsp(1'b1, 32'h00000001, 1'b0);
    cyc(); mem_rsp(1'b0, 32'h0, 1'b0);
    #1;
    chk("bad_follow_rdata", obi_rdata_o, 32'h00000001);
    chk("bad_follow_rchk", obi_rchk_o, 5'b0_0001);
    cyc();

    // bad achk while one backend read pending
    drive_req(32'h500, 1'b0, 32'h0, 1'b0);
    cyc(); drive_req(32'h504, 1'b0, 32'h0, 1'b1);
    #1;
    chk("pend_gnt_blocked", obi_gnt_o, 0);
    cyc(); mem_rsp(1'b1, 32'hCAFE0001, 1'b0);
    #1;
    chk("pend_gnt_blocked2", obi_gnt_o, 0);
    cyc(); mem_rsp(1'b0, 32'h0, 1'b0);
    #1;
    chk("pend_rdata_first", obi_rdata_o, 32'hCAFE0001);
    chk("pend_gnt_after", obi_gnt_o, 1);
    cyc(); idle_req();
    #1;
    chk("pend_integ", integrity_err_o, 1);
    chk("pend_rvalid_gap", obi_rvalid_o, 0);
    cyc();
    #1;
    chk("pend_rvalid2", obi_rvalid_o, 1);
    chk("pend_err2", obi_err_o, 1);
    chk("pend_rdata2", obi_rdata_o, 0);
    chk("pend_integ_clear", integrity_err_o, 0);
    cyc();

    // reqpar error alone, with non-zero prot/memtype/dbg
    obi_prot_i = 3'b101; obi_memtype_i = 2'b01; obi_dbg_i = 1'b1;
    drive_req(32'h600, 1'b0, 32'h0, 1'b0);
    obi_reqpar_i = 1'b1;
    #1;
    chk("par_gnt", obi_gnt_o, 1);
    chk("par_gntpar", obi_gntpar_o, 0);
    cyc(); idle_req(); mem_rsp(1'b1, 32'h12345678, 1'b0);
    obi_prot_i = '0; obi_memtype_i = '0; obi_dbg_i = 1'b0;
    #1;
    chk("par_integ", integrity_err_o, 1);
    cyc(); mem_rsp(1'b1, 32'h0BAD0BAD, 1'b1);
    #1;
    chk("par_rdata", obi_rdata_o, 32'h12345678);
    chk("par_rchk", obi_rchk_o, 5'b0_0100);
    chk("par_integ_clear", integrity_err_o, 0);
    cyc(); mem_rsp(1'b0, 32'h0, 1'b0);
    #1;
    chk("spur_rvalid", obi_rvalid_o, 0);
    chk("spur_integ", integrity_err_o, 1);
    chk("spur_rdata_hold", obi_rdata_o, 32'h12345678);
    cyc();

    // reset with two outstanding
    drive_req(32'h700, 1'b0, 32'h0, 1'b0);
    cyc(); cyc();
    mem_rsp(1'b1, 32'h77777777, 1'b0);
    idle_req();
    #1;
    rst = 1'b1;
    #1;
    chk("arst_cnt", dut.cnt_q, 0);
    chk("arst_rvalid", obi_rvalid_o, 0);
    cyc();
    rst = 1'b0;
    cyc(); mem_rsp(1'b0, 32'h0, 1'b0);
    #1;
    chk("arst_no_late_rvalid", obi_rvalid_o, 0);
    chk("arst_spur_integ", integrity_err_o, 1);
    chk("arst_rdata", obi_rdata_o, 0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
    $fatal(1, "timeout");
  end

endmodule
